master_bridge_r_channel_sync_fifo: RTL and testbench
====================================================

// Module: master_bridge_r_channel_sync_fifo
// PURPOSE
//  Single-clock R-channel buffer between the PCIe completion path and the AXI R interface of the master bridge.
//  Stores per-burst info (AXI read info + ARLEN) and per-beat data in two paired FIFOs.
//  Presents a first-word-fall-through AXI-style R stream with generated last, exact occupancy counts,
//  almost-full back-pressure and sticky overflow/underflow error flags.
// PARAMETERS
//  DW               32        dword width in bits
//  BEAT_SIZE        32*DW     data beat width in bits
//  R_CH_INFO_WIDTH  30        burst info width (RID, RRESP, etc.; opaque here)
//  LEN_WIDTH        8         burst length field width (beats-1, AXI ARLEN encoding)
//  INFO_DEPTH       8         info FIFO depth, power of 2, >=2
//  DATA_DEPTH       32        data FIFO depth, power of 2, >=2
//  AFULL_MARGIN     4         o_w_almost_full asserts when free data slots <= AFULL_MARGIN
// PORTS
//  i_clk             in   1                          clock
//  i_n_rst           in   1                          async active-low reset
//  i_w_info_inc      in   1                          push burst info entry
//  i_w_info          in   R_CH_INFO_WIDTH            burst info
//  i_w_len           in   LEN_WIDTH                  burst beats-1
//  i_w_data_inc      in   1                          push one data beat
//  i_w_data          in   BEAT_SIZE                  data beat
//  o_w_info_full     out  1                          info FIFO full
//  o_w_data_full     out  1                          data FIFO full
//  o_w_full_flag     out  1                          info_full | data_full
//  o_w_almost_full   out  1                          data free slots <= AFULL_MARGIN
//  o_r_valid         out  1                          head beat available
//  i_r_ready         in   1                          consumer accepts head beat
//  o_r_data          out  BEAT_SIZE                  head data beat
//  o_r_info          out  R_CH_INFO_WIDTH            head burst info
//  o_r_last          out  1                          head beat is last of burst
//  o_r_empty_flag    out  1                          ~o_r_valid
//  o_info_count      out  $clog2(INFO_DEPTH)+1       info occupancy
//  o_data_count      out  $clog2(DATA_DEPTH)+1       data occupancy
//  o_err_ovf         out  1                          sticky: push attempted while that FIFO full
//  o_err_udf         out  1                          sticky: i_r_ready with info present but no data... see below
// BEHAVIOUR
//  - Reset (async, i_n_rst=0): pointers, counts, beat counter, error flags = 0; o_r_valid=0, o_r_last=0,
//    o_r_empty_flag=1, all full/almost-full=0 (almost-full=1 only if AFULL_MARGIN>=DATA_DEPTH). o_r_data/o_r_info don't-care.
//  - Pointers ADDR+1 bits, binary; full = MSB differs & rest equal; empty = equal. Wrap silently.
//  - Push accepted iff inc & ~full of that FIFO; full FIFO ignores push even with same-cycle pop; rejected push sets o_err_ovf.
//  - Written entry visible at read side next cycle (1-cycle write-to-valid latency); FWFT, no read latency.
//  - o_r_valid = info_nonempty & data_nonempty. Beat transfer = o_r_valid & i_r_ready; pops one data entry.
//  - beat_cnt (LEN_WIDTH bits) counts beats of head burst; o_r_last = o_r_valid & (beat_cnt == head_len).
//  - On transfer with o_r_last: pop info entry, beat_cnt <= 0; else transfer: beat_cnt <= beat_cnt+1.
//  - i_r_ready with ~o_r_valid: no pop, no state change; sets o_err_udf only if info present & data empty
//    for a burst whose beat_cnt>0 (mid-burst starvation), else ignored.
//  - Simultaneous push and pop on one FIFO: both take effect; count unchanged.
//  - Counts exact, registered, = wr_ptr - rd_ptr; almost-full from registered data count.
//  - Data may arrive before its info; held until info present. Error flags clear only on reset.
// STRUCTURE
//  - Shared package/header master_bridge_pkg: info entry packing localparams ({len,info}), pointer-width function.
//  - Sub-module master_bridge_sync_fifo (generic FWFT, DATA_WIDTH/FIFO_DEPTH params, full/empty/count,
//    reject-on-full), instantiated twice: info (R_CH_INFO_WIDTH+LEN_WIDTH) and data (BEAT_SIZE).
//  - Top holds beat counter, last/valid logic, flag merge, error flags.
// TESTING
//  1 Reset mid-burst: push info len=3 + 2 beats, pop 1, assert i_n_rst -> counts 0, valid 0, empty 1, errors 0.
//  2 Push info len=3 + 4 beats, ready=1 -> 4 transfers, o_r_last only on 4th, info_count 1->0 on 4th.
//  3 Fill data FIFO 32 beats, push 33rd -> o_w_data_full=1, 33rd dropped, o_err_ovf=1; almost_full at count 28.
//  4 Data before info: 2 beats, no info -> valid 0; push info len=1 -> valid next cycle, last on beat 2.
//  5 Full data FIFO with simultaneous push+pop -> push rejected, count 31, o_err_ovf=1.
//  6 Back-to-back bursts len=0 x INFO_DEPTH with random ready -> every beat last, info order/data order preserved, wrap correct.

Source files
------------

// File: rtl/master_bridge_pkg.sv
// Shared definitions for the master bridge R-channel buffer: default widths,
// info-entry packing ({len, info}) and FIFO pointer sizing.
package master_bridge_pkg;

    localparam int unsigned DW_DEF              = 32;
    localparam int unsigned BEAT_SIZE_DEF       = 32 * DW_DEF;
    localparam int unsigned R_CH_INFO_WIDTH_DEF = 30;
    localparam int unsigned LEN_WIDTH_DEF       = 8;

    // Pointer/count width: one extra bit beyond the address distinguishes full from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

    // Width of a packed info entry {len, info}.
    function automatic int unsigned info_entry_w(input int unsigned info_w, input int unsigned len_w);
        return info_w + len_w;
    endfunction

    // LSB position of the len field inside a packed info entry.
    function automatic int unsigned info_len_lsb(input int unsigned info_w);
        return info_w;
    endfunction

endpackage

// File: rtl/master_bridge_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO; pushes into a full FIFO
// are dropped, pops from an empty FIFO are ignored.
module master_bridge_sync_fifo
    import master_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic [DATA_WIDTH-1:0]           push_data,
    input  logic                            pop,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            full,
    output logic                            empty,
    output logic [ptr_w(FIFO_DEPTH)-1:0]    count
);

    localparam int unsigned PTR_W  = ptr_w(FIFO_DEPTH);
    localparam int unsigned ADDR_W = PTR_W - 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr_nxt;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

    // Next pointer values, shared by the pointer and count registers.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (push_ok) wr_ptr_nxt = wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
    end

    // Storage write; no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

    // Pointers and exact registered occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= wr_ptr_nxt - rd_ptr_nxt;
        end
    end

endmodule

// File: rtl/master_bridge_r_channel_sync_fifo.sv
// R-channel buffer: pairs a burst-info FIFO with a beat-data FIFO and presents
// an FWFT R stream with generated last, occupancy counts and sticky error flags.
module master_bridge_r_channel_sync_fifo
    import master_bridge_pkg::*;
#(
    parameter int unsigned DW              = DW_DEF,
    parameter int unsigned BEAT_SIZE       = 32 * DW,
    parameter int unsigned R_CH_INFO_WIDTH = R_CH_INFO_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH       = LEN_WIDTH_DEF,
    parameter int unsigned INFO_DEPTH      = 8,
    parameter int unsigned DATA_DEPTH      = 32,
    parameter int unsigned AFULL_MARGIN    = 4
) (
    input  logic                            i_clk,
    input  logic                            i_n_rst,
    input  logic                            i_w_info_inc,
    input  logic [R_CH_INFO_WIDTH-1:0]      i_w_info,
    input  logic [LEN_WIDTH-1:0]            i_w_len,
    input  logic                            i_w_data_inc,
    input  logic [BEAT_SIZE-1:0]            i_w_data,
    output logic                            o_w_info_full,
    output logic                            o_w_data_full,
    output logic                            o_w_full_flag,
    output logic                            o_w_almost_full,
    output logic                            o_r_valid,
    input  logic                            i_r_ready,
    output logic [BEAT_SIZE-1:0]            o_r_data,
    output logic [R_CH_INFO_WIDTH-1:0]      o_r_info,
    output logic                            o_r_last,
    output logic                            o_r_empty_flag,
    output logic [ptr_w(INFO_DEPTH)-1:0]    o_info_count,
    output logic [ptr_w(DATA_DEPTH)-1:0]    o_data_count,
    output logic                            o_err_ovf,
    output logic                            o_err_udf
);

    localparam int unsigned ENTRY_W = info_entry_w(R_CH_INFO_WIDTH, LEN_WIDTH);
    localparam int unsigned LEN_LSB = info_len_lsb(R_CH_INFO_WIDTH);

    logic [ENTRY_W-1:0]   info_head;
    logic [LEN_WIDTH-1:0] head_len;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 info_empty;
    logic                 data_empty;
    logic                 xfer;
    logic                 last_c;
    logic                 ovf_c;
    logic                 udf_c;

    master_bridge_sync_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .FIFO_DEPTH (INFO_DEPTH)
    ) u_info_fifo (
        .clk       (i_clk),
        .rst_n     (i_n_rst),
        .push      (i_w_info_inc),
        .push_data ({i_w_len, i_w_info}),
        .pop       (xfer & last_c),
        .rd_data   (info_head),
        .full      (o_w_info_full),
        .empty     (info_empty),
        .count     (o_info_count)
    );

    master_bridge_sync_fifo #(
        .DATA_WIDTH (BEAT_SIZE),
        .FIFO_DEPTH (DATA_DEPTH)
    ) u_data_fifo (
        .clk       (i_clk),
        .rst_n     (i_n_rst),
        .push      (i_w_data_inc),
        .push_data (i_w_data),
        .pop       (xfer),
        .rd_data   (o_r_data),
        .full      (o_w_data_full),
        .empty     (data_empty),
        .count     (o_data_count)
    );

    assign head_len        = info_head[LEN_LSB +: LEN_WIDTH];
    assign o_r_info        = info_head[R_CH_INFO_WIDTH-1:0];
    assign o_r_valid       = ~info_empty & ~data_empty;
    assign o_r_empty_flag  = ~o_r_valid;
    assign last_c          = o_r_valid & (beat_cnt == head_len);
    assign o_r_last        = last_c;
    assign xfer            = o_r_valid & i_r_ready;
    assign o_w_full_flag   = o_w_info_full | o_w_data_full;
    assign o_w_almost_full = (DATA_DEPTH - 32'(o_data_count)) <= AFULL_MARGIN;

    // A rejected push on either FIFO; a ready that finds the current burst starved mid-way.
    assign ovf_c = (i_w_info_inc & o_w_info_full) | (i_w_data_inc & o_w_data_full);
    assign udf_c = i_r_ready & ~o_r_valid & ~info_empty & data_empty & (beat_cnt != '0);

    // Beat position within the head burst.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= last_c ? '0 : beat_cnt + LEN_WIDTH'(1);
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            o_err_ovf <= 1'b0;
            o_err_udf <= 1'b0;
        end else begin
            if (ovf_c) o_err_ovf <= 1'b1;
            if (udf_c) o_err_udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_master_bridge_r_channel_sync_fifo.sv
// Bench for the R-channel buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_master_bridge_r_channel_sync_fifo;

    localparam int unsigned BW = 1024;
    localparam int unsigned IW = 30;
    localparam int unsigned LW = 8;
    localparam int unsigned IDEPTH = 8;
    localparam int unsigned DDEPTH = 32;
    localparam int unsigned MARGIN = 4;

    typedef struct packed {
        logic [LW-1:0] len;
        logic [IW-1:0] info;
    } ent_t;

    logic          clk;
    logic          rst_n;
    logic          w_info_inc;
    logic [IW-1:0] w_info;
    logic [LW-1:0] w_len;
    logic          w_data_inc;
    logic [BW-1:0] w_data;
    logic          info_full, data_full, full_flag, almost_full;
    logic          r_valid, r_ready, r_last, r_empty;
    logic [BW-1:0] r_data;
    logic [IW-1:0] r_info;
    logic [3:0]    info_count;
    logic [5:0]    data_count;
    logic          err_ovf, err_udf;

    int n_total = 0;
    int n_pass  = 0;

    // reference model state
    ent_t          miq[$];
    logic [BW-1:0] mdq[$];
    int            m_beat = 0;
    bit            m_ovf = 0;
    bit            m_udf = 0;

    master_bridge_r_channel_sync_fifo dut (
        .i_clk           (clk),
        .i_n_rst         (rst_n),
        .i_w_info_inc    (w_info_inc),
        .i_w_info        (w_info),
        .i_w_len         (w_len),
        .i_w_data_inc    (w_data_inc),
        .i_w_data        (w_data),
        .o_w_info_full   (info_full),
        .o_w_data_full   (data_full),
        .o_w_full_flag   (full_flag),
        .o_w_almost_full (almost_full),
        .o_r_valid       (r_valid),
        .i_r_ready       (r_ready),
        .o_r_data        (r_data),
        .o_r_info        (r_info),
        .o_r_last        (r_last),
        .o_r_empty_flag  (r_empty),
        .o_info_count    (info_count),
        .o_data_count    (data_count),
        .o_err_ovf       (err_ovf),
        .o_err_udf       (err_udf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [BW-1:0] mk(input int n);
        logic [BW-1:0] d;
        for (int i = 0; i < 32; i++) d[i*32 +: 32] = 32'(n * 64 + i);
        return d;
    endfunction

    // Reference model: advances on each clock from the rules of the buffer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miq.delete();
            mdq.delete();
            m_beat = 0;
            m_ovf  = 0;
            m_udf  = 0;
        end else begin
            bit v, lst, ifull, dfull;
            v     = (miq.size() > 0) && (mdq.size() > 0);
            lst   = v && (m_beat == int'(miq[0].len));
            ifull = (miq.size() == IDEPTH);
            dfull = (mdq.size() == DDEPTH);
            if (r_ready && !v && miq.size() > 0 && mdq.size() == 0 && m_beat != 0) m_udf = 1;
            if ((w_info_inc && ifull) || (w_data_inc && dfull)) m_ovf = 1;
            if (v && r_ready) begin
                void'(mdq.pop_front());
                if (lst) begin
                    void'(miq.pop_front());
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (w_info_inc && !ifull) miq.push_back('{len: w_len, info: w_info});
            if (w_data_inc && !dfull) mdq.push_back(w_data);
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        bit mv, ml;
        mv = (miq.size() > 0) && (mdq.size() > 0);
        ml = mv && (m_beat == int'(miq[0].len));
        chk("r_valid",     BW'(r_valid),     BW'(mv));
        chk("r_empty",     BW'(r_empty),     BW'(!mv));
        chk("r_last",      BW'(r_last),      BW'(ml));
        chk("info_full",   BW'(info_full),   BW'(miq.size() == IDEPTH));
        chk("data_full",   BW'(data_full),   BW'(mdq.size() == DDEPTH));
        chk("full_flag",   BW'(full_flag),   BW'(miq.size() == IDEPTH || mdq.size() == DDEPTH));
        chk("almost_full", BW'(almost_full), BW'((DDEPTH - mdq.size()) <= MARGIN));
        chk("info_count",  BW'(info_count),  BW'(miq.size()));
        chk("data_count",  BW'(data_count),  BW'(mdq.size()));
        chk("err_ovf",     BW'(err_ovf),     BW'(m_ovf));
        chk("err_udf",     BW'(err_udf),     BW'(m_udf));
        if (mv) begin
            chk("r_data", r_data, mdq[0]);
            chk("r_info", BW'(r_info), BW'(miq[0].info));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_info_inc = 0;
        w_data_inc = 0;
        r_ready    = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
    endtask

    task automatic drain(input string name);
        idle_inputs();
        r_ready = 1;
        for (int i = 0; i < 100; i++) begin
            if (!((miq.size() > 0) && (mdq.size() > 0))) break;
            step();
        end
        r_ready = 0;
        chk(name, BW'(r_valid), BW'(0));
    endtask

    initial begin
        int pushed;
        rst_n = 0;
        w_info = '0;
        w_len = '0;
        w_data = '0;
        idle_inputs();
        step();
        step();
        chk("rst_valid", BW'(r_valid), BW'(0));
        chk("rst_empty", BW'(r_empty), BW'(1));
        chk("rst_almost_full", BW'(almost_full), BW'(0));
        rst_n = 1;
        step();

        // 1: reset in the middle of a burst
        w_info_inc = 1; w_info = 30'h111; w_len = 8'd3;
        w_data_inc = 1; w_data = mk(1);
        step();
        w_info_inc = 0; w_data = mk(2);
        step();
        w_data_inc = 0; r_ready = 1;
        chk("t1_valid_before_pop", BW'(r_valid), BW'(1));
        step();
        r_ready = 0;
        chk("t1_data_count", BW'(data_count), BW'(1));
        rst_n = 0;
        step();
        chk("t1_rst_info_count", BW'(info_count), BW'(0));
        chk("t1_rst_data_count", BW'(data_count), BW'(0));
        chk("t1_rst_valid", BW'(r_valid), BW'(0));
        chk("t1_rst_empty", BW'(r_empty), BW'(1));
        chk("t1_rst_ovf", BW'(err_ovf), BW'(0));
        rst_n = 1;
        step();

        // 2: four-beat burst, last only on the fourth transfer
        w_info_inc = 1; w_info = 30'h222; w_len = 8'd3;
        for (int i = 0; i < 4; i++) begin
            w_data_inc = 1; w_data = mk(10 + i);
            step();
            w_info_inc = 0;
        end
        w_data_inc = 0;
        r_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_last", BW'(r_last), BW'(i == 3));
            chk("t2_info_count", BW'(info_count), BW'(1));
            chk("t2_data", r_data, mk(10 + i));
            step();
        end
        r_ready = 0;
        chk("t2_info_count_end", BW'(info_count), BW'(0));
        chk("t2_valid_end", BW'(r_valid), BW'(0));

        // 3: fill data FIFO, almost-full at 28, 33rd push dropped
        for (int k = 1; k <= 32; k++) begin
            w_data_inc = 1; w_data = mk(100 + k);
            step();
            if (k == 27) chk("t3_afull_27", BW'(almost_full), BW'(0));
            if (k == 28) chk("t3_afull_28", BW'(almost_full), BW'(1));
            if (k == 31) chk("t3_full_31", BW'(data_full), BW'(0));
        end
        chk("t3_full_32", BW'(data_full), BW'(1));
        chk("t3_ovf_before", BW'(err_ovf), BW'(0));
        w_data = mk(200);
        step();
        w_data_inc = 0;
        chk("t3_count_33", BW'(data_count), BW'(32));
        chk("t3_ovf", BW'(err_ovf), BW'(1));
        do_reset();

        // 5: full data FIFO with simultaneous push and pop
        w_info_inc = 1; w_info = 30'h333; w_len = 8'd31;
        for (int k = 0; k < 32; k++) begin
            w_data_inc = 1; w_data = mk(300 + k);
            step();
            w_info_inc = 0;
        end
        w_data = mk(400); r_ready = 1;
        step();
        w_data_inc = 0; r_ready = 0;
        chk("t5_count", BW'(data_count), BW'(31));
        chk("t5_ovf", BW'(err_ovf), BW'(1));
        chk("t5_head", r_data, mk(301));
        drain("t5_drained");

        // 4: data before info, then a two-beat burst (ready with no info is not an error)
        r_ready = 1;
        for (int k = 0; k < 2; k++) begin
            w_data_inc = 1; w_data = mk(500 + k);
            step();
        end
        w_data_inc = 0; r_ready = 0;
        chk("t4_valid_no_info", BW'(r_valid), BW'(0));
        chk("t4_udf", BW'(err_udf), BW'(0));
        w_info_inc = 1; w_info = 30'h444; w_len = 8'd1;
        step();
        w_info_inc = 0;
        chk("t4_valid", BW'(r_valid), BW'(1));
        chk("t4_last_beat1", BW'(r_last), BW'(0));
        r_ready = 1;
        step();
        chk("t4_last_beat2", BW'(r_last), BW'(1));
        step();
        r_ready = 0;
        chk("t4_valid_end", BW'(r_valid), BW'(0));

        // mid-burst starvation sets the underflow flag
        w_info_inc = 1; w_info = 30'h555; w_len = 8'd2;
        w_data_inc = 1; w_data = mk(600);
        step();
        idle_inputs();
        r_ready = 1;
        step();
        step();
        chk("udf_set", BW'(err_udf), BW'(1));
        r_ready = 0;
        for (int k = 1; k < 3; k++) begin
            w_data_inc = 1; w_data = mk(600 + k);
            step();
        end
        drain("udf_drained");

        // 6: back-to-back single-beat bursts with random ready, wrapping the info FIFO
        pushed = 0;
        for (int c = 0; c < 300; c++) begin
            if (pushed >= 20) break;
            w_info_inc = (miq.size() < IDEPTH) && (mdq.size() < DDEPTH);
            w_data_inc = w_info_inc;
            w_info = 30'(32'h700 + 32'(pushed));
            w_len  = 8'd0;
            w_data = mk(700 + pushed);
            if (w_info_inc) pushed++;
            r_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("t6_all_pushed", BW'(pushed), BW'(20));
        drain("t6_drained");
        chk("t6_info_count", BW'(info_count), BW'(0));
        chk("t6_data_count", BW'(data_count), BW'(0));
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
